grey_window_buffer: RTL and testbench

Downstream consumer of the AHB master's read path. Fetches 32-bit greyscale words (four 8-bit pixels each) through the `re` / `read_complete` handshake and unpacks them into a raster pixel stream. Two internal line buffers build a 3x3 pixel neighbourhood, and the block emits one window per interior pixel to the edge-detection kernel.

---
 rtl/grey_window_buffer.sv | 215 +++++++++++++++++++++
 tb/tb_grey_window_buffer.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/grey_window_buffer.sv
// ---------------------------------------------------------------------------
// grey_window_buffer
//
// Fetches 32-bit greyscale words (four 8-bit pixels, byte 0 leftmost) from
// the AHB master read path, unpacks them into a raster pixel stream and
// builds a 3x3 neighbourhood around every interior pixel using two line
// buffers plus a three-column window register.
//
// Optional feature macro: GREY_WIN_COORD_EN
//   defined   -> win_x / win_y ports and coordinate registers exist
//   undefined -> no coordinate ports or registers (default build)
//
// Ports:
//   clk            in   system clock, rising edge
//   rst            in   synchronous active-high reset
//   start          in   one-cycle pulse, latches dimensions, (re)starts frame
//   img_width      in   frame width in pixels
//   img_height     in   frame height in pixels
//   greyscale_data in   fetched word
//   read_complete  in   greyscale_data valid this cycle
//   re             out  read request (high while fetching)
//   win_valid      out  one-cycle strobe, win holds a new window
//   win            out  3x3 window, byte 0 top-left ... byte 8 bottom-right
//   win_x, win_y   out  window centre column/row (GREY_WIN_COORD_EN only)
//   frame_done     out  one-cycle pulse at end of frame
//   err            out  sticky illegal-dimension flag
// ---------------------------------------------------------------------------
module grey_window_buffer #(
    parameter int MAX_WIDTH = 640
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] img_width,
    input  logic [15:0] img_height,
    input  logic [31:0] greyscale_data,
    input  logic        read_complete,
    output logic        re,
    output logic        win_valid,
    output logic [71:0] win,
`ifdef GREY_WIN_COORD_EN
    output logic [15:0] win_x,
    output logic [15:0] win_y,
`endif
    output logic        frame_done,
    output logic        err
);

    localparam int AW = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_UNPACK,
        S_DONE
    } state_t;

    state_t      r_state;
    state_t      w_nextState;

    logic [15:0] r_width;
    logic [15:0] r_height;
    logic [15:0] r_col;
    logic [15:0] r_row;
    logic [1:0]  r_byte;
    logic [31:0] r_word;

    // Line buffers: lb1 holds the row two above, lb0 the row directly above.
    logic [7:0]  r_lb0 [MAX_WIDTH];
    logic [7:0]  r_lb1 [MAX_WIDTH];

    // Window columns packed as {bottom, middle, top}; colA is the older one.
    logic [23:0] r_colA;
    logic [23:0] r_colB;

    logic [AW-1:0] w_lbIdx;
    logic [7:0]  w_pixel;
    logic [7:0]  w_top;
    logic [7:0]  w_mid;
    logic [71:0] w_window;
    logic        w_legal;
    logic        w_lastCol;
    logic        w_lastPixel;
    logic        w_unpack;
    logic        w_emit;

    // Combinational helpers: current pixel, line-buffer taps and the window
    // that the current pixel completes.
    always_comb begin
        w_lbIdx     = r_col[AW-1:0];
        w_pixel     = r_word[{r_byte, 3'b000} +: 8];
        w_top       = r_lb1[w_lbIdx];
        w_mid       = r_lb0[w_lbIdx];
        w_legal     = (img_width[1:0] == 2'b00) && (img_width >= 16'd4) &&
                      (img_width <= 16'(MAX_WIDTH)) && (img_height >= 16'd3);
        w_lastCol   = (r_col == r_width - 16'd1);
        w_lastPixel = w_lastCol && (r_row == r_height - 16'd1);
        // start aborts the frame, so the pixel of that cycle is discarded
        w_unpack    = (r_state == S_UNPACK) && !start;
        w_emit      = w_unpack && (r_row >= 16'd2) && (r_col >= 16'd2);
        w_window    = {w_pixel, r_colB[23:16], r_colA[23:16],
                       w_mid,   r_colB[15:8],  r_colA[15:8],
                       w_top,   r_colB[7:0],   r_colA[7:0]};
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state and Moore outputs; start overrides everything but reset.
    always_comb begin
        w_nextState = r_state;
        re          = 1'b0;
        frame_done  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_nextState = S_IDLE;
            end
            S_FETCH: begin
                re = 1'b1;
                if (read_complete) begin
                    w_nextState = S_UNPACK;
                end
            end
            S_UNPACK: begin
                if (r_byte == 2'd3) begin
                    w_nextState = w_lastPixel ? S_DONE : S_FETCH;
                end
            end
            S_DONE: begin
                frame_done  = 1'b1;
                w_nextState = S_IDLE;
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase
        if (start) begin
            w_nextState = w_legal ? S_FETCH : S_IDLE;
        end
    end

    // Counters, word capture, window columns and the registered window.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_width   <= '0;
            r_height  <= '0;
            r_col     <= '0;
            r_row     <= '0;
            r_byte    <= '0;
            r_word    <= '0;
            r_colA    <= '0;
            r_colB    <= '0;
            win       <= '0;
            win_valid <= 1'b0;
            err       <= 1'b0;
        end else begin
            win_valid <= w_emit;
            if (start) begin
                r_width  <= img_width;
                r_height <= img_height;
                r_col    <= '0;
                r_row    <= '0;
                r_byte   <= '0;
                err      <= !w_legal;
            end else if ((r_state == S_FETCH) && read_complete) begin
                r_word <= greyscale_data;
                r_byte <= '0;
            end else if (w_unpack) begin
                r_byte <= r_byte + 2'd1;
                r_colA <= r_colB;
                r_colB <= {w_pixel, w_mid, w_top};
                if (w_lastCol) begin
                    r_col <= '0;
                    r_row <= r_row + 16'd1;
                end else begin
                    r_col <= r_col + 16'd1;
                end
                if (w_emit) begin
                    win <= w_window;
                end
            end
        end
    end

    // Line-buffer update: the row above moves up one line, the new pixel
    // takes its place. Contents need no reset; they are rewritten before use.
    always_ff @(posedge clk) begin
        if (!rst && w_unpack) begin
            r_lb1[w_lbIdx] <= w_mid;
            r_lb0[w_lbIdx] <= w_pixel;
        end
    end

`ifdef GREY_WIN_COORD_EN
    // Window centre, registered alongside win and zero between windows.
    always_ff @(posedge clk) begin
        if (rst || !w_emit) begin
            win_x <= '0;
            win_y <= '0;
        end else begin
            win_x <= r_col - 16'd1;
            win_y <= r_row - 16'd1;
        end
    end
`else
    // No coordinate registers; column/row counters remain for control.
`endif

endmodule

// File: tb/tb_grey_window_buffer.sv
// ---------------------------------------------------------------------------
// tb_grey_window_buffer
//
// Randomised scoreboard bench for grey_window_buffer. A reference model keeps
// the whole frame as a flat pixel array and, whenever a word is handed over,
// cuts the expected 3x3 windows straight out of that image and queues them.
// An independent monitor pops the queue on every win_valid strobe.
// ---------------------------------------------------------------------------
module tb_grey_window_buffer;

    localparam int MAXW = 640;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] img_width;
    logic [15:0] img_height;
    logic [31:0] greyscale_data;
    logic        read_complete;
    logic        re;
    logic        win_valid;
    logic [71:0] win;
`ifdef GREY_WIN_COORD_EN
    logic [15:0] win_x;
    logic [15:0] win_y;
`endif
    logic        frame_done;
    logic        err;

    grey_window_buffer #(.MAX_WIDTH(MAXW)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .img_width      (img_width),
        .img_height     (img_height),
        .greyscale_data (greyscale_data),
        .read_complete  (read_complete),
        .re             (re),
        .win_valid      (win_valid),
        .win            (win),
`ifdef GREY_WIN_COORD_EN
        .win_x          (win_x),
        .win_y          (win_y),
`endif
        .frame_done     (frame_done),
        .err            (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [71:0] win;
        logic [15:0] x;
        logic [15:0] y;
        bit          last;
    } exp_t;

    exp_t       expQ[$];
    logic [7:0] img[int];
    int         pixCount = 0;
    int         curW = 4;
    int         curH = 3;
    int         winCount = 0;
    int         doneCount = 0;
    int         nVectors = 0;
    int         nMiscompares = 0;

    task automatic checkOutput(input string name, input logic [71:0] act,
                               input logic [71:0] exp);
        nVectors++;
        if (act !== exp) begin
            nMiscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: store the word's pixels in raster order and queue a
    // window for every pixel that completes a 3x3 interior neighbourhood.
    task automatic modelWord(input logic [31:0] w);
        for (int k = 0; k < 4; k++) begin
            int   c;
            int   r;
            exp_t e;
            c = pixCount % curW;
            r = pixCount / curW;
            img[pixCount] = w[8*k +: 8];
            pixCount++;
            if (r >= 2 && c >= 2) begin
                for (int j = 0; j < 9; j++) begin
                    e.win[8*j +: 8] = img[(r - 2 + j / 3) * curW + (c - 2 + j % 3)];
                end
                e.x    = 16'(c - 1);
                e.y    = 16'(r - 1);
                e.last = (c == curW - 1) && (r == curH - 1);
                expQ.push_back(e);
            end
        end
    endtask

    function automatic logic [7:0] pixelFor(input int mode, input int idx, input int w);
        int c;
        int r;
        c = idx % w;
        r = idx / w;
        if (mode == 0) return 8'((r << 4) | c);
        if (mode == 1) return 8'(idx);
        return 8'($urandom);
    endfunction

    // Monitor: every window strobe is matched against the head of the queue,
    // and frame_done must coincide exactly with the last window of a frame.
    always @(negedge clk) begin
        if (win_valid === 1'b1) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpectedWindow", 72'(win_valid), 72'd0);
            end else begin
                exp_t e;
                e = expQ.pop_front();
                winCount++;
                checkOutput("windowData", win, e.win);
                checkOutput("frameDoneOnWindow", 72'(frame_done), 72'(e.last));
`ifdef GREY_WIN_COORD_EN
                checkOutput("winX", 72'(win_x), 72'(e.x));
                checkOutput("winY", 72'(win_y), 72'(e.y));
`endif
            end
        end else if (frame_done !== 1'b0) begin
            checkOutput("frameDoneWithoutWindow", 72'(frame_done), 72'd0);
        end
        if (frame_done === 1'b1) doneCount++;
    end

    // Issue a start pulse (optionally with a simultaneous read_complete that
    // must be dropped) and check the request/err response one cycle later.
    task automatic doStart(input int w, input int h, input bit rcAlso);
        bit legal;
        legal = (w % 4 == 0) && (w >= 4) && (w <= MAXW) && (h >= 3);
        @(negedge clk);
        start          = 1'b1;
        img_width      = 16'(w);
        img_height     = 16'(h);
        read_complete  = rcAlso;
        greyscale_data = $urandom;
        expQ.delete();
        img.delete();
        pixCount  = 0;
        curW      = w;
        curH      = h;
        winCount  = 0;
        doneCount = 0;
        @(negedge clk);
        start         = 1'b0;
        read_complete = 1'b0;
        checkOutput("reAfterStart", 72'(re), 72'(legal));
        checkOutput("errAfterStart", 72'(err), 72'(!legal));
    endtask

    // Hand one word over after re has been held for 'delay' cycles, then
    // check re stays low across the four unpack cycles.
    task automatic sendWord(input logic [31:0] w, input int delay, input bit stray,
                            input bit last);
        int waited = 0;
        while (re !== 1'b1 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (re !== 1'b1) begin
            checkOutput("reTimeout", 72'(re), 72'd1);
            return;
        end
        for (int i = 0; i < delay; i++) begin
            @(negedge clk);
            checkOutput("reHeldWaiting", 72'(re), 72'd1);
        end
        read_complete  = 1'b1;
        greyscale_data = w;
        modelWord(w);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            read_complete  = stray && (i == 2);
            greyscale_data = $urandom;
            checkOutput("reLowUnpack", 72'(re), 72'd0);
        end
        @(negedge clk);
        read_complete = 1'b0;
        checkOutput("reAfterWord", 72'(re), 72'(!last));
    endtask

    // Drive up to maxWords words of a frame. delay < 0 picks random delays;
    // word longIdx waits ten cycles instead.
    task automatic applyStimulus(input int w, input int h, input int mode,
                                 input int maxWords, input int delay,
                                 input bit stray, input int longIdx);
        int total;
        int n;
        total = (w * h) / 4;
        n = (maxWords < total) ? maxWords : total;
        for (int i = 0; i < n; i++) begin
            logic [31:0] word;
            int d;
            for (int k = 0; k < 4; k++) word[8*k +: 8] = pixelFor(mode, 4 * i + k, w);
            d = (i == longIdx) ? 10 : ((delay >= 0) ? delay : int'($urandom_range(0, 2)));
            sendWord(word, d, stray && (i % 2 == 0), i == total - 1);
        end
    endtask

    task automatic endFrame(input int w, input int h);
        repeat (2) @(negedge clk);
        checkOutput("pendingWindows", 72'(expQ.size()), 72'd0);
        checkOutput("windowCount", 72'(winCount), 72'((w - 2) * (h - 2)));
        checkOutput("frameDoneCount", 72'(doneCount), 72'd1);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst            = 1'b1;
        start          = 1'b0;
        read_complete  = 1'b0;
        img_width      = '0;
        img_height     = '0;
        greyscale_data = '0;
        repeat (3) @(negedge clk);
        checkOutput("resetRe", 72'(re), 72'd0);
        checkOutput("resetWinValid", 72'(win_valid), 72'd0);
        checkOutput("resetFrameDone", 72'(frame_done), 72'd0);
        checkOutput("resetErr", 72'(err), 72'd0);
        checkOutput("resetWin", win, 72'd0);
`ifdef GREY_WIN_COORD_EN
        checkOutput("resetWinX", 72'(win_x), 72'd0);
        checkOutput("resetWinY", 72'(win_y), 72'd0);
`endif
        rst = 1'b0;

        // Smallest legal frame with the 0xRC pattern, answered one cycle late.
        doStart(4, 3, 1'b0);
        applyStimulus(4, 3, 0, 1000, 1, 1'b0, -1);
        endFrame(4, 3);

        // Illegal dimensions: re must stay low and err must stick.
        doStart(6, 3, 1'b0);
        repeat (3) begin
            @(negedge clk);
            checkOutput("reIdleAfterErr", 72'(re), 72'd0);
            checkOutput("errSticky", 72'(err), 72'd1);
        end
        doStart(MAXW + 4, 3, 1'b0);
        doStart(8, 2, 1'b0);

        // Legal frame with stray read_complete pulses and one long wait.
        doStart(8, 4, 1'b0);
        applyStimulus(8, 4, 2, 1000, -1, 1'b1, 2);
        endFrame(8, 4);

        // Abort a 16x8 frame after five words; the restart coincides with a
        // read_complete whose word must be dropped.
        doStart(16, 8, 1'b0);
        applyStimulus(16, 8, 2, 5, -1, 1'b0, -1);
        doStart(8, 4, 1'b1);
        applyStimulus(8, 4, 2, 1000, -1, 1'b0, -1);
        endFrame(8, 4);

        // Reset while unpacking, then read_complete must be ignored.
        doStart(8, 4, 1'b0);
        read_complete  = 1'b1;
        greyscale_data = $urandom;
        @(negedge clk);
        read_complete = 1'b0;
        rst           = 1'b1;
        @(negedge clk);
        checkOutput("rstRe", 72'(re), 72'd0);
        checkOutput("rstWinValid", 72'(win_valid), 72'd0);
        checkOutput("rstFrameDone", 72'(frame_done), 72'd0);
        rst = 1'b0;
        expQ.delete();
        for (int i = 0; i < 6; i++) begin
            read_complete  = 1'b1;
            greyscale_data = $urandom;
            @(negedge clk);
            checkOutput("reIgnoredAfterRst", 72'(re), 72'd0);
        end
        read_complete = 1'b0;

        // A few random legal frames.
        for (int f = 0; f < 3; f++) begin
            int w;
            int h;
            w = 4 * int'($urandom_range(1, 8));
            h = int'($urandom_range(3, 6));
            doStart(w, h, 1'b0);
            applyStimulus(w, h, 2, 1000, -1, 1'b1, -1);
            endFrame(w, h);
        end

        // Widest legal frame with ramp data.
        doStart(MAXW, 3, 1'b0);
        applyStimulus(MAXW, 3, 1, 1000000, 0, 1'b0, -1);
        endFrame(MAXW, 3);

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule
